jk_count_sequencer: RTL

//   Controller that sequences a bank of WIDTH JK flip-flops (sub-module jk_ff_cell) as a

---
 rtl/jk_seq_pkg.sv | 18 +
 rtl/jk_ff_cell.sv | 38 +++
 rtl/jk_count_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared state encoding and JK excitation codes for the count sequencer
package jk_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Excitation codes packed as {j, k}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_ff_cell.sv
// rtl/jk_ff_cell.sv - falling-edge JK flip-flop with asynchronous active-low clear
module jk_ff_cell
    import jk_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // Next-state from the JK characteristic table
    always_comb begin
        q_d = q_q;
        case ({j, k})
            JK_HOLD: q_d = q_q;
            JK_CLR:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TOG:  q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    // Storage element; clears immediately on reset, updates on the falling edge
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_count_sequencer.sv
// rtl/jk_count_sequencer.sv - FSM driving a bank of JK cells as a loadable up/down counter
module jk_count_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done
);

    state_t state_q;
    state_t state_d;

    // Prefix-reduction carries: all lower bits 1 (up) / all lower bits 0 (down)
    logic lower_ones;
    logic lower_zeros;

    // Control state register; shares the falling edge with the JK cells
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-bit excitation; every bit holds unless a state says otherwise
    always_comb begin
        state_d     = state_q;
        j           = '0;
        k           = '0;
        lower_ones  = 1'b1;
        lower_zeros = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                for (int i = 0; i < WIDTH; i++) begin
                    {j[i], k[i]} = load_val[i] ? JK_SET : JK_CLR;
                end
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (cnt == term_val) begin
                    state_d = ST_DONE;
                end else begin
                    // A bit toggles when every lower bit is at the carry/borrow value
                    for (int i = 0; i < WIDTH; i++) begin
                        if (dir ? lower_ones : lower_zeros) begin
                            {j[i], k[i]} = JK_TOG;
                        end
                        lower_ones  = lower_ones & cnt[i];
                        lower_zeros = lower_zeros & ~cnt[i];
                    end
                end
            end
            ST_PAUSE: begin
                if (start) state_d = ST_RUN;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One JK cell per counter bit
    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_cell
            jk_ff_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .j     (j[g]),
                .k     (k[g]),
                .q     (cnt[g])
            );
        end
    endgenerate

    assign busy = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done = (state_q == ST_DONE);

endmodule
